// File: rtl/rr_encoder16to4.sv
// Sequential 16-to-4 round-robin encoder: collects request pulses into a sticky
// pending register and presents one index at a time over a valid/ready handshake.
module rr_encoder16to4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        ready,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  ptr;
    logic [3:0]  ptr_next;
    logic [3:0]  code_next;
    logic [15:0] pending_next;
    logic [15:0] avail;
    logic [3:0]  sel_idx;
    logic        sel_found;
    logic        load;

    // Requests arriving on this edge take part in this edge's selection.
    assign avail = pending | req;
    assign load  = (state == IDLE) || ready;
    assign valid = (state == PRESENT);

    // First set bit of avail, scanning upward from ptr with a 4-bit wrap.
    always_comb begin : rr_scan
        logic [3:0] cand;
        // NOTE: every variable gets a default before the loop, so no latch is inferred.
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!sel_found && avail[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        code_next    = code;
        ptr_next     = ptr;
        pending_next = avail;
        if (load) begin
            if (sel_found) begin
                state_next   = PRESENT;
                code_next    = sel_idx;
                ptr_next     = sel_idx + 4'd1;
                pending_next = avail & ~(16'd1 << sel_idx);
            end else begin
                // Nothing left: drop to IDLE, keeping the last code on the bus.
                state_next   = IDLE;
                pending_next = '0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= '0;
            ptr     <= '0;
            pending <= '0;
        end else begin
            state   <= state_next;
            code    <= code_next;
            ptr     <= ptr_next;
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_rr_encoder16to4.sv
// Directed self-checking bench for rr_encoder16to4: reset, single request, burst,
// backpressure, pointer wrap and re-request of the presented line.
module tb_rr_encoder16to4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        ready;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] pending;

    int checks = 0;
    int errors = 0;

    rr_encoder16to4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ready   (ready),
        .code    (code),
        .valid   (valid),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        #1;
        checks++;
        if ({valid, code, pending} !== {1'b0, 4'd0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: valid=%b code=%0d pending=%h, want 0/0/0000", valid, code, pending);
        end
        tick();
        rst_n = 1'b1;
        req   = 16'h0420;
        tick();
        req = '0;
        checks++;
        if ({valid, code, pending} !== {1'b1, 4'd5, 16'h0400}) begin
            errors++;
            $display("FAIL reset_preload: valid=%b code=%0d pending=%h, want 1/5/0400", valid, code, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, code, pending} !== {1'b0, 4'd0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_async: valid=%b code=%0d pending=%h, want 0/0/0000", valid, code, pending);
        end
        #2 rst_n = 1'b1;
        req   = 16'h0001;
        ready = 1'b1;
        tick();
        req = '0;
        checks++;
        if ({valid, code} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL reset_release: valid=%b code=%0d, want 1/0", valid, code);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: valid=%b, want 0", valid);
        end
    endtask

    task automatic test_single();
        ready = 1'b1;
        req   = 16'h0020;
        tick();
        req = '0;
        checks++;
        if ({valid, code, dut.ptr} !== {1'b1, 4'd5, 4'd6}) begin
            errors++;
            $display("FAIL single_present: valid=%b code=%0d ptr=%0d, want 1/5/6", valid, code, dut.ptr);
        end
        tick();
        checks++;
        if ({valid, pending} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL single_accept: valid=%b pending=%h, want 0/0000", valid, pending);
        end
    endtask

    task automatic test_burst();
        do_reset();
        ready = 1'b1;
        req   = 16'hFFFF;
        tick();
        req = '0;
        checks++;
        if (pending !== 16'hFFFE) begin
            errors++;
            $display("FAIL burst_pending: pending=%h, want fffe", pending);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({valid, code} !== {1'b1, 4'(i)}) begin
                errors++;
                $display("FAIL burst_code_%0d: valid=%b code=%0d, want 1/%0d", i, valid, code, i);
            end
            tick();
        end
        checks++;
        if ({valid, pending} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL burst_end: valid=%b pending=%h, want 0/0000", valid, pending);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        req   = 16'h0208;
        tick();
        req = '0;
        checks++;
        if ({valid, code, pending} !== {1'b1, 4'd3, 16'h0200}) begin
            errors++;
            $display("FAIL bp_first: valid=%b code=%0d pending=%h, want 1/3/0200", valid, code, pending);
        end
        req = 16'h0001;
        tick();
        req = '0;
        checks++;
        if ({valid, code, pending} !== {1'b1, 4'd3, 16'h0201}) begin
            errors++;
            $display("FAIL bp_merge: valid=%b code=%0d pending=%h, want 1/3/0201", valid, code, pending);
        end
        tick();
        checks++;
        if ({valid, code, dut.ptr} !== {1'b1, 4'd3, 4'd4}) begin
            errors++;
            $display("FAIL bp_hold: valid=%b code=%0d ptr=%0d, want 1/3/4", valid, code, dut.ptr);
        end
        ready = 1'b1;
        tick();
        checks++;
        if ({valid, code, dut.ptr} !== {1'b1, 4'd9, 4'd10}) begin
            errors++;
            $display("FAIL bp_second: valid=%b code=%0d ptr=%0d, want 1/9/10", valid, code, dut.ptr);
        end
        tick();
        checks++;
        if ({valid, code, pending} !== {1'b1, 4'd0, 16'h0000}) begin
            errors++;
            $display("FAIL bp_third: valid=%b code=%0d pending=%h, want 1/0/0000", valid, code, pending);
        end
        tick();
        checks++;
        if ({valid, code} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL bp_idle: valid=%b code=%0d, want 0/0 (code held)", valid, code);
        end
    endtask

    task automatic test_wrap();
        ready = 1'b1;
        req   = 16'h4000;
        tick();
        checks++;
        if ({valid, code, dut.ptr} !== {1'b1, 4'd14, 4'd15}) begin
            errors++;
            $display("FAIL wrap_14: valid=%b code=%0d ptr=%0d, want 1/14/15", valid, code, dut.ptr);
        end
        req = 16'h8004;
        tick();
        req = '0;
        checks++;
        if ({valid, code, dut.ptr, pending} !== {1'b1, 4'd15, 4'd0, 16'h0004}) begin
            errors++;
            $display("FAIL wrap_15: valid=%b code=%0d ptr=%0d pending=%h, want 1/15/0/0004", valid, code, dut.ptr, pending);
        end
        tick();
        checks++;
        if ({valid, code, dut.ptr} !== {1'b1, 4'd2, 4'd3}) begin
            errors++;
            $display("FAIL wrap_2: valid=%b code=%0d ptr=%0d, want 1/2/3", valid, code, dut.ptr);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: valid=%b, want 0", valid);
        end
    endtask

    task automatic test_rerequest();
        ready = 1'b0;
        req   = 16'h0080;
        tick();
        checks++;
        if ({valid, code, pending} !== {1'b1, 4'd7, 16'h0000}) begin
            errors++;
            $display("FAIL rereq_first: valid=%b code=%0d pending=%h, want 1/7/0000", valid, code, pending);
        end
        tick();
        req = '0;
        checks++;
        if ({valid, code, pending} !== {1'b1, 4'd7, 16'h0080}) begin
            errors++;
            $display("FAIL rereq_pending: valid=%b code=%0d pending=%h, want 1/7/0080", valid, code, pending);
        end
        ready = 1'b1;
        tick();
        checks++;
        if ({valid, code, pending, dut.ptr} !== {1'b1, 4'd7, 16'h0000, 4'd8}) begin
            errors++;
            $display("FAIL rereq_again: valid=%b code=%0d pending=%h ptr=%0d, want 1/7/0000/8", valid, code, pending, dut.ptr);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL rereq_idle: valid=%b, want 0", valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_rerequest();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
